nh_lcd_bus_arbiter: RTL and testbench

Shares the single 8080-style LCD parallel bus between two masters: the command/register writer (requester 0) and the pixel data writer (requester 1). Grants the bus whole-transaction, so a frame is never preempted. Inserts an idle turnaround between owners. Registers the muxed bus signals to the physical pins and reports starvation status.

---
 rtl/nh_lcd_bus_arbiter_pkg.sv | 20 ++
 rtl/nh_lcd_bus_arbiter_mux.sv | 15 +
 rtl/nh_lcd_bus_arbiter.sv | 98 +++++++++
 tb/tb_nh_lcd_bus_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/nh_lcd_bus_arbiter_pkg.sv
// nh_lcd_bus_arbiter_pkg: state encodings, owner codes and idle bus constants for the LCD bus arbiter.
package nh_lcd_bus_arbiter_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CMD_OWN  = 2'd1;
  localparam logic [1:0] ST_DATA_OWN = 2'd2;
  localparam logic [1:0] ST_TURN     = 2'd3;
  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_CMD   = 2'd1;
  localparam logic [1:0] OWNER_DATA  = 2'd2;
  localparam logic       IDLE_CMD_MODE = 1'b1;
  localparam logic [7:0] IDLE_DATA     = 8'h00;
  typedef struct packed {
    logic       cmd_mode;
    logic       write;
    logic       read;
    logic       data_out_en;
    logic [7:0] data;
  } bus_t;
  localparam bus_t IDLE_BUS = '{cmd_mode: IDLE_CMD_MODE, write: 1'b0, read: 1'b0, data_out_en: 1'b0, data: IDLE_DATA};
endpackage

// File: rtl/nh_lcd_bus_arbiter_mux.sv
// nh_lcd_bus_mux: registered 2:1 LCD bus mux, forced idle whenever no grant is registered.
module nh_lcd_bus_mux
  import nh_lcd_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] owner,
  input  bus_t       cmd_bus,
  input  bus_t       dat_bus,
  output bus_t       phy
);
  always_ff @(posedge clk)
    if (rst) phy <= IDLE_BUS;
    else phy <= owner == OWNER_CMD ? cmd_bus : owner == OWNER_DATA ? dat_bus : IDLE_BUS;
endmodule

// File: rtl/nh_lcd_bus_arbiter.sv
// nh_lcd_bus_arbiter: whole-transaction arbiter for the shared 8080 LCD bus with turnaround and starvation status.
module nh_lcd_bus_arbiter
  import nh_lcd_bus_arbiter_pkg::*;
#(
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 65535,
  parameter int HOLD_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_clear_status,
  input  logic        i_cmd_req,
  output logic        o_cmd_gnt,
  input  logic        i_cmd_cmd_mode,
  input  logic        i_cmd_write,
  input  logic        i_cmd_read,
  input  logic        i_cmd_data_out_en,
  input  logic [7:0]  i_cmd_data_out,
  input  logic        i_dat_req,
  output logic        o_dat_gnt,
  input  logic        i_dat_cmd_mode,
  input  logic        i_dat_write,
  input  logic        i_dat_read,
  input  logic        i_dat_data_out_en,
  input  logic [7:0]  i_dat_data_out,
  output logic [7:0]  o_data_in,
  output logic        o_cmd_mode,
  output logic        o_write,
  output logic        o_read,
  output logic        o_data_out_en,
  output logic [7:0]  o_data_out,
  input  logic [7:0]  i_data_in,
  output logic [1:0]  o_owner,
  output logic        o_starve,
  output logic [31:0] debug
);
  localparam int TW = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;
  logic [1:0] state;
  logic last_grant;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;
  logic own, own_req, other_req, inc, pick_dat, starve_set;
  bus_t cmd_bus, dat_bus, phy;
  always_comb begin
    own        = state == ST_CMD_OWN || state == ST_DATA_OWN;
    own_req    = state == ST_CMD_OWN ? i_cmd_req : i_dat_req;
    other_req  = state == ST_CMD_OWN ? i_dat_req : i_cmd_req;
    inc        = own && other_req && hold_cnt != '1;
    // last_grant high means data went last, so cmd wins the tie
    pick_dat   = i_dat_req && (!i_cmd_req || !last_grant);
    starve_set = inc && hold_cnt == HOLD_WIDTH'(MAX_HOLD - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= ST_IDLE;
      o_cmd_gnt  <= 1'b0;
      o_dat_gnt  <= 1'b0;
      last_grant <= 1'b1;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      o_starve   <= 1'b0;
      o_data_in  <= 8'h00;
    end else begin
      o_data_in <= i_data_in;
      o_starve  <= starve_set | (o_starve & ~i_clear_status);
      if (inc) hold_cnt <= hold_cnt + 1'b1;
      if (state == ST_IDLE) begin
        if (i_enable && (i_cmd_req || i_dat_req)) begin
          state      <= pick_dat ? ST_DATA_OWN : ST_CMD_OWN;
          o_cmd_gnt  <= !pick_dat;
          o_dat_gnt  <= pick_dat;
          last_grant <= pick_dat;
          hold_cnt   <= '0;
        end
      end else if (own) begin
        if (!own_req) begin
          state     <= TURNAROUND > 0 ? ST_TURN : ST_IDLE;
          o_cmd_gnt <= 1'b0;
          o_dat_gnt <= 1'b0;
          turn_cnt  <= '0;
        end
      end else begin
        turn_cnt <= turn_cnt + 1'b1;
        if (turn_cnt == TW'(TURNAROUND - 1)) state <= ST_IDLE;
      end
    end
  assign o_owner = {o_dat_gnt, o_cmd_gnt};
  assign cmd_bus = '{cmd_mode: i_cmd_cmd_mode, write: i_cmd_write, read: i_cmd_read, data_out_en: i_cmd_data_out_en, data: i_cmd_data_out};
  assign dat_bus = '{cmd_mode: i_dat_cmd_mode, write: i_dat_write, read: i_dat_read, data_out_en: i_dat_data_out_en, data: i_dat_data_out};
  nh_lcd_bus_mux u_mux (.clk(clk), .rst(rst), .owner(o_owner), .cmd_bus(cmd_bus), .dat_bus(dat_bus), .phy(phy));
  assign o_cmd_mode    = phy.cmd_mode;
  assign o_write       = phy.write;
  assign o_read        = phy.read;
  assign o_data_out_en = phy.data_out_en;
  assign o_data_out    = phy.data;
  assign debug = {16'(hold_cnt), 8'h00, last_grant, o_starve, o_owner, 2'b00, state};
endmodule

// File: tb/tb_nh_lcd_bus_arbiter.sv
// tb_nh_lcd_bus_arbiter: directed checks of grant order, turnaround, bus mux, starvation and reset.
module tb_nh_lcd_bus_arbiter;
  logic clk = 0, rst = 1, en = 1, clr = 0;
  logic cmd_req = 0, cmd_mode = 1, cmd_wr = 0, cmd_rd = 0, cmd_oe = 0;
  logic dat_req = 0, dat_mode = 1, dat_wr = 0, dat_rd = 0, dat_oe = 0;
  logic [7:0] cmd_d = 0, dat_d = 0, din = 0;
  logic cmd_gnt, dat_gnt, p_mode, p_wr, p_rd, p_oe, starve;
  logic [7:0] p_d, p_din;
  logic [1:0] owner;
  logic [31:0] dbg;
  logic z_cmd_gnt, z_dat_gnt, z_mode, z_wr, z_rd, z_oe, z_starve;
  logic [7:0] z_d, z_din;
  logic [1:0] z_owner;
  logic [31:0] z_dbg;
  int total = 0, bad = 0, n;
  always #5 clk = ~clk;
  nh_lcd_bus_arbiter #(.TURNAROUND(2), .MAX_HOLD(8), .HOLD_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_clear_status(clr),
    .i_cmd_req(cmd_req), .o_cmd_gnt(cmd_gnt), .i_cmd_cmd_mode(cmd_mode), .i_cmd_write(cmd_wr),
    .i_cmd_read(cmd_rd), .i_cmd_data_out_en(cmd_oe), .i_cmd_data_out(cmd_d),
    .i_dat_req(dat_req), .o_dat_gnt(dat_gnt), .i_dat_cmd_mode(dat_mode), .i_dat_write(dat_wr),
    .i_dat_read(dat_rd), .i_dat_data_out_en(dat_oe), .i_dat_data_out(dat_d),
    .o_data_in(p_din), .o_cmd_mode(p_mode), .o_write(p_wr), .o_read(p_rd), .o_data_out_en(p_oe),
    .o_data_out(p_d), .i_data_in(din), .o_owner(owner), .o_starve(starve), .debug(dbg));
  nh_lcd_bus_arbiter #(.TURNAROUND(0), .MAX_HOLD(8), .HOLD_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .i_enable(en), .i_clear_status(clr),
    .i_cmd_req(cmd_req), .o_cmd_gnt(z_cmd_gnt), .i_cmd_cmd_mode(cmd_mode), .i_cmd_write(cmd_wr),
    .i_cmd_read(cmd_rd), .i_cmd_data_out_en(cmd_oe), .i_cmd_data_out(cmd_d),
    .i_dat_req(dat_req), .o_dat_gnt(z_dat_gnt), .i_dat_cmd_mode(dat_mode), .i_dat_write(dat_wr),
    .i_dat_read(dat_rd), .i_dat_data_out_en(dat_oe), .i_dat_data_out(dat_d),
    .o_data_in(z_din), .o_cmd_mode(z_mode), .o_write(z_wr), .o_read(z_rd), .o_data_out_en(z_oe),
    .o_data_out(z_d), .i_data_in(din), .o_owner(z_owner), .o_starve(z_starve), .debug(z_dbg));
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_debug", dbg, 32'h0000_0080);
    chk("rst_bus", {p_mode, p_wr, p_rd, p_oe, p_d}, {4'b1000, 8'h00});
    chk("rst_din", p_din, 8'h00);
    rst = 0;
    cmd_req = 1; cmd_mode = 0; cmd_wr = 1; cmd_oe = 1; cmd_d = 8'h2C;
    tick();
    chk("cmd_gnt", {dat_gnt, cmd_gnt, owner}, {2'b01, 2'd1});
    chk("cmd_bus_lag", p_wr, 1'b0);
    tick();
    chk("cmd_bus", {p_mode, p_wr, p_oe, p_d}, {3'b011, 8'h2C});
    cmd_wr = 0;
    tick();
    chk("cmd_wr_pulse", {p_wr, p_d}, {1'b0, 8'h2C});
    cmd_wr = 1; tick(2);
    cmd_req = 0;
    tick();
    chk("cmd_release", {cmd_gnt, dbg[3:0]}, {1'b0, 4'd3});
    tick();
    chk("turn_bus_idle", {p_mode, p_wr, p_oe, p_d}, {3'b100, 8'h00});
    chk("turn1_state", dbg[3:0], 4'd3);
    tick();
    chk("turn_done", dbg[3:0], 4'd0);
    cmd_mode = 1; cmd_wr = 0; cmd_oe = 0; cmd_d = 0;
    rst = 1; tick(); rst = 0;
    cmd_req = 1; dat_req = 1;
    tick();
    chk("tie1_cmd", {cmd_gnt, dat_gnt}, 2'b10);
    tick(2);
    cmd_req = 0;
    n = 0;
    while (!dat_gnt && n < 20) begin tick(); n++; end
    chk("gap_cycles", n, 4);
    dat_req = 0; tick(5);
    cmd_req = 1; tick();
    chk("cmd_only", {cmd_gnt, dat_gnt}, 2'b10);
    cmd_req = 0; tick(5);
    cmd_req = 1; dat_req = 1;
    tick();
    chk("tie2_data", {cmd_gnt, dat_gnt, owner}, {2'b01, 2'd2});
    chk("hold_zero", dbg[31:16], 16'd0);
    tick(7);
    chk("starve_pre", {starve, dbg[31:16]}, {1'b0, 16'd7});
    clr = 1; tick(); clr = 0;
    chk("starve_set_wins", starve, 1'b1);
    tick(12);
    chk("no_preempt", {dat_gnt, cmd_gnt, starve}, 3'b101);
    clr = 1; tick(); clr = 0;
    chk("starve_clr", {starve, dbg[6]}, 2'b00);
    chk("hold_cnt", dbg[31:16], 16'd21);
    cmd_req = 0; dat_req = 0; tick(6);
    en = 0; cmd_req = 1; tick(3);
    chk("en_block", {cmd_gnt, dbg[3:0]}, {1'b0, 4'd0});
    en = 1; tick();
    chk("en_grant", cmd_gnt, 1'b1);
    en = 0; tick(3);
    chk("en_keep", cmd_gnt, 1'b1);
    cmd_req = 0; dat_req = 1; tick(6);
    chk("en_no_new", {dat_gnt, dbg[3:0]}, {1'b0, 4'd0});
    en = 1; tick();
    chk("en_resume", dat_gnt, 1'b1);
    dat_mode = 0; dat_wr = 1; dat_oe = 1; dat_d = 8'hA5; din = 8'h5A;
    tick();
    chk("dat_bus", {p_mode, p_wr, p_oe, p_d}, {3'b011, 8'hA5});
    chk("din_reg", p_din, 8'h5A);
    rst = 1; tick();
    chk("rst_mid", {dat_gnt, owner, p_mode, p_wr, p_oe, p_d}, {1'b0, 2'd0, 3'b100, 8'h00});
    rst = 0; dat_req = 0;
    cmd_req = 1; cmd_mode = 0; cmd_wr = 1; cmd_oe = 1; cmd_d = 8'h11; dat_d = 8'h22;
    tick();
    chk("ta0_gnt", z_cmd_gnt, 1'b1);
    tick();
    cmd_req = 0; dat_req = 1;
    tick();
    chk("ta0_release", {z_cmd_gnt, z_owner, z_dbg[3:0], z_d}, {1'b0, 2'd0, 4'd0, 8'h11});
    tick();
    chk("ta0_idle_bus", {z_dat_gnt, z_wr, z_mode, z_d}, {3'b101, 8'h00});
    tick();
    chk("ta0_dat_bus", {z_wr, z_mode, z_d}, {2'b10, 8'h22});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
